ad7606_ctrl: RTL and testbench
==============================

AD7606_CTRL -- requirements
Module: ad7606_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 3: adc_reset high width in clk cycles, at least 50 ns at 50 MHz.
REQ-002 SHALL have parameter CONVST_CYCLES, default 2: adc_convst low pulse width in cycles.
REQ-003 SHALL have parameter RD_LOW_CYCLES, default 2, and RD_HIGH_CYCLES, default 1: adc_rd_n low and high widths per channel.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 250: maximum cycles spent waiting for each busy edge.
REQ-005 SHALL have parameter NUM_CH, default 8: channels read per frame, range 1..8.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 power  input  1  enable; low forces OFF state.
REQ-009 start  input  1  single-cycle conversion request.
REQ-010 adc_busy  input  1  ADC BUSY pin, asynchronous.
REQ-011 adc_frstdata  input  1  ADC FRSTDATA pin, sampled with data.
REQ-012 adc_db  input  16  ADC parallel data bus.
REQ-013 adc_reset  output  1  ADC RESET pin.
REQ-014 adc_convst  output  1  ADC CONVST A/B, tied together, idle high.
REQ-015 adc_cs_n, adc_rd_n  output  1 each  chip select and read strobe, active-low.
REQ-016 ready  output  1  high only in IDLE.
REQ-017 sample_data  output  16; sample_ch  output  3; sample_valid  output  1: one-cycle sample strobe.
REQ-018 frame_done  output  1  one-cycle pulse after the last channel.
REQ-019 err_timeout, err_frst  output  1 each  sticky error flags, cleared by the next accepted start.

Function
REQ-020 States SHALL be OFF, RESET, IDLE, CONVST, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE.
REQ-021 OFF->RESET on power high; RESET drives adc_reset high for RESET_CYCLES, then moves to IDLE.
REQ-022 IDLE->CONVST on start; start SHALL be ignored in every other state.
REQ-023 CONVST drives adc_convst low for CONVST_CYCLES, then moves to WAIT_HI.
REQ-024 adc_busy SHALL pass through a 2-flop synchronizer; all busy decisions use the synchronized value.
REQ-025 WAIT_HI->WAIT_LO on synchronized busy high; WAIT_LO->RD_LO on synchronized busy low.
REQ-026 Each of WAIT_HI and WAIT_LO SHALL count cycles; on reaching BUSY_TIMEOUT, set err_timeout and go to IDLE without reading.
REQ-027 adc_cs_n SHALL be low from entry to the first RD_LO until exit from the last RD_HI.
REQ-028 RD_LO holds adc_rd_n low for RD_LOW_CYCLES; on its last cycle, register adc_db and adc_frstdata.
REQ-029 sample_valid SHALL pulse the cycle after data capture, with sample_ch equal to the channel index, 0-based.
REQ-030 RD_HI holds adc_rd_n high for RD_HIGH_CYCLES, then returns to RD_LO, or goes to DONE after channel NUM_CH-1.
REQ-031 err_frst SHALL be set if captured frstdata is 0 on channel 0 or 1 on any other channel; the frame still completes.
REQ-032 DONE SHALL pulse frame_done for one cycle, then move to IDLE.
REQ-033 Power low in any state SHALL, next cycle, enter OFF, drive all ADC pins idle, and abort the frame without frame_done.
REQ-034 sample_data SHALL be a raw 16-bit two's-complement pass-through with no arithmetic.

Reset
REQ-035 On rst: state OFF, adc_reset 0, adc_convst 1, adc_cs_n 1, adc_rd_n 1, ready 0, sample_data 0, sample_ch 0, strobes 0, error flags 0, counters 0, synchronizer 0.
REQ-036 After rst deasserts with power already high, the block SHALL run the full RESET sequence.

Structure
REQ-037 Package ad7606_pkg SHALL hold the state enum, a 16-bit sample type, and default timing constants.
REQ-038 One sub-module, sync2, a 2-flop synchronizer, SHALL be used for adc_busy.

Verification
REQ-039 power 0->1 at 100 ns -> adc_reset high exactly 3 cycles, then ready high.
REQ-040 start in IDLE; ADC model busy high 2 cycles after convst rises, low after 200 cycles -> 8 sample_valid pulses with ch 0..7 and data 0x1000+ch, then frame_done, then ready.
REQ-041 start with busy held low -> err_timeout after 250 cycles in WAIT_HI, no sample_valid, then IDLE.
REQ-042 frstdata high on ch 3 -> err_frst set and all 8 samples still emitted.
REQ-043 power dropped during channel 4 read -> next cycle adc_cs_n=1, adc_rd_n=1, no frame_done; on power restore, full reset sequence.
REQ-044 start pulsed during WAIT_LO -> ignored; exactly one frame produced.

Source files
------------

// File: rtl/ad7606_pkg.sv
// ad7606_pkg -- shared types and default timing for the AD7606 controller.
//   state_t  : controller FSM states (also exported on the debug port)
//   sample_t : raw 16-bit two's-complement ADC word
//   DEF_*    : default timing in clk cycles (50 MHz clk assumed)
package ad7606_pkg;

  typedef enum logic [3:0] {
    OFF, RESET, IDLE, CONVST, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE
  } state_t;

  typedef logic [15:0] sample_t;

  localparam int DEF_RESET_CYCLES   = 3;    // 60 ns at 50 MHz, ADC needs >= 50 ns
  localparam int DEF_CONVST_CYCLES  = 2;
  localparam int DEF_RD_LOW_CYCLES  = 2;
  localparam int DEF_RD_HIGH_CYCLES = 1;
  localparam int DEF_BUSY_TIMEOUT   = 250;
  localparam int DEF_NUM_CH         = 8;

  // Width of the shared timing counter; must hold BUSY_TIMEOUT.
  localparam int CNT_W = 16;

endpackage

// File: rtl/ad7606_ctrl_if.sv
// ad7606_ctrl_if -- AD7606 parallel-interface pins.
//   master : controller side (drives reset/convst/cs_n/rd_n, reads busy/frstdata/db)
//   slave  : ADC side (the converter or its model)
interface ad7606_ctrl_if;
  import ad7606_pkg::*;

  logic    adc_reset;
  logic    adc_convst;   // CONVST A and B tied together, idle high
  logic    adc_cs_n;
  logic    adc_rd_n;
  logic    adc_busy;     // asynchronous to clk
  logic    adc_frstdata;
  sample_t adc_db;

  modport master (
    output adc_reset, adc_convst, adc_cs_n, adc_rd_n,
    input  adc_busy, adc_frstdata, adc_db
  );

  modport slave (
    input  adc_reset, adc_convst, adc_cs_n, adc_rd_n,
    output adc_busy, adc_frstdata, adc_db
  );
endinterface

// File: rtl/ad7606_ctrl_sync2.sv
// sync2 -- two-flop synchronizer for a single asynchronous level.
//   clk, rst : destination clock, async active-high reset (output resets low)
//   d        : asynchronous input
//   q        : synchronized output, two clk cycles of latency
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ad7606_ctrl.sv
// ad7606_ctrl -- AD7606 parallel-mode conversion and readout controller.
//   clk, rst     : single rising-edge clock, async active-high reset
//   power        : enable; low forces OFF with all ADC pins idle
//   start        : one-cycle conversion request
//   adc          : AD7606 pins (ad7606_ctrl_if.master)
//   ready        : high only in IDLE
//   sample_*     : captured word, channel index and one-cycle strobe
//   frame_done   : one-cycle pulse after the last channel of a frame
//   err_timeout  : sticky, busy edge not seen within BUSY_TIMEOUT cycles
//   err_frst     : sticky, FRSTDATA disagreed with the channel position
//   dbg_state    : current FSM state
//
// Handshake: start is accepted only on a cycle where ready is high; in every
// other cycle it is ignored. sample_valid and frame_done are single-cycle
// strobes with no backpressure, so the consumer must take them when they fire.
module ad7606_ctrl
  import ad7606_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int CONVST_CYCLES  = DEF_CONVST_CYCLES,
  parameter int RD_LOW_CYCLES  = DEF_RD_LOW_CYCLES,
  parameter int RD_HIGH_CYCLES = DEF_RD_HIGH_CYCLES,
  parameter int BUSY_TIMEOUT   = DEF_BUSY_TIMEOUT,
  parameter int NUM_CH         = DEF_NUM_CH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power,
  input  logic          start,
  ad7606_ctrl_if.master adc,
  output logic          ready,
  output sample_t       sample_data,
  output logic [2:0]    sample_ch,
  output logic          sample_valid,
  output logic          frame_done,
  output logic          err_timeout,
  output logic          err_frst,
  output state_t        dbg_state
);

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONVST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDL_LAST   = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDH_LAST   = CNT_W'(RD_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       CH_LAST    = 3'(NUM_CH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;     // cycles spent in the current timed state
  logic [2:0]       ch;      // channel currently being read
  logic             busy_s;
  logic             adc_reset_r;
  logic             convst_r;
  logic             cs_n_r;
  logic             rd_n_r;

  sync2 u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d   (adc.adc_busy),
    .q   (busy_s)
  );

  assign adc.adc_reset  = adc_reset_r;
  assign adc.adc_convst = convst_r;
  assign adc.adc_cs_n   = cs_n_r;
  assign adc.adc_rd_n   = rd_n_r;
  assign dbg_state      = state;

  // Every pin and status output is registered and updated on the transition
  // edge, so each one is valid for exactly the cycles its state is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OFF;
      cnt          <= '0;
      ch           <= '0;
      adc_reset_r  <= 1'b0;
      convst_r     <= 1'b1;
      cs_n_r       <= 1'b1;
      rd_n_r       <= 1'b1;
      ready        <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      err_timeout  <= 1'b0;
      err_frst     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (!power) begin
        // Abort whatever is in flight; error flags keep their history.
        state       <= OFF;
        cnt         <= '0;
        ch          <= '0;
        adc_reset_r <= 1'b0;
        convst_r    <= 1'b1;
        cs_n_r      <= 1'b1;
        rd_n_r      <= 1'b1;
        ready       <= 1'b0;
      end else begin
        case (state)
          OFF: begin
            state       <= RESET;
            adc_reset_r <= 1'b1;
            cnt         <= '0;
          end
          RESET: begin
            if (cnt == RESET_LAST) begin
              state       <= IDLE;
              adc_reset_r <= 1'b0;
              ready       <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE: begin
            if (start) begin
              state       <= CONVST;
              convst_r    <= 1'b0;
              ready       <= 1'b0;
              cnt         <= '0;
              ch          <= '0;
              err_timeout <= 1'b0;
              err_frst    <= 1'b0;
            end
          end
          CONVST: begin
            if (cnt == CONV_LAST) begin
              state    <= WAIT_HI;
              convst_r <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (busy_s) begin
              state <= WAIT_LO;
              cnt   <= '0;
            end else if (cnt == BUSY_LAST) begin
              state       <= IDLE;
              err_timeout <= 1'b1;
              ready       <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (!busy_s) begin
              state  <= RD_LO;
              cs_n_r <= 1'b0;
              rd_n_r <= 1'b0;
              cnt    <= '0;
            end else if (cnt == BUSY_LAST) begin
              state       <= IDLE;
              err_timeout <= 1'b1;
              ready       <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RD_LO: begin
            if (cnt == RDL_LAST) begin
              // Capture on the last low cycle; the strobe is visible next cycle.
              state        <= RD_HI;
              rd_n_r       <= 1'b1;
              cnt          <= '0;
              sample_data  <= adc.adc_db;
              sample_ch    <= ch;
              sample_valid <= 1'b1;
              // FRSTDATA must be high on channel 0 and low on all others.
              if (adc.adc_frstdata != (ch == 3'd0)) err_frst <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RD_HI: begin
            if (cnt == RDH_LAST) begin
              cnt <= '0;
              if (ch == CH_LAST) begin
                state      <= DONE;
                cs_n_r     <= 1'b1;
                frame_done <= 1'b1;
              end else begin
                state  <= RD_LO;
                rd_n_r <= 1'b0;
                ch     <= ch + 3'd1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DONE: begin
            state <= IDLE;
            ready <= 1'b1;
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad7606_ctrl.sv
// tb_ad7606_ctrl -- self-checking bench for ad7606_ctrl with a behavioural
// AD7606 model, a table of frame scenarios, randomized frames, and directed
// power/reset sequences.
module tb_ad7606_ctrl;
  import ad7606_pkg::*;

  localparam int NCH     = 8;
  localparam int BUSY_TO = 250;
  localparam int RST_W   = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       power;
  logic       start;
  logic       ready, sample_valid, frame_done, err_timeout, err_frst;
  sample_t    sample_data;
  logic [2:0] sample_ch;
  state_t     dbg_state;

  ad7606_ctrl_if adc ();

  ad7606_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .power        (power),
    .start        (start),
    .adc          (adc),
    .ready        (ready),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .frame_done   (frame_done),
    .err_timeout  (err_timeout),
    .err_frst     (err_frst),
    .dbg_state    (dbg_state)
  );

  always #10 clk = ~clk;

  // ---------------- ADC model ----------------
  // busy_mode: 0 = normal pulse, 1 = stuck low, 2 = stuck high
  int          busy_mode  = 0;
  int          busy_delay = 2;
  int          busy_len   = 200;
  int          frst_bad   = -1;   // channel whose FRSTDATA is inverted
  logic [15:0] ch_data [NCH];
  int          conv_age   = -1;   // cycles since CONVST rose
  logic        convst_q   = 1'b1;
  logic        rd_q       = 1'b1;
  int          rd_idx     = 0;    // ADC's internal output-channel pointer
  logic        reading;

  always @(posedge clk) begin
    convst_q <= adc.adc_convst;
    if (adc.adc_convst === 1'b1 && convst_q === 1'b0) conv_age <= 0;
    else if (conv_age >= 0) conv_age <= conv_age + 1;
    rd_q <= adc.adc_rd_n;
    if (adc.adc_convst === 1'b0) rd_idx <= 0;
    else if (adc.adc_cs_n === 1'b0 && adc.adc_rd_n === 1'b1 && rd_q === 1'b0)
      rd_idx <= rd_idx + 1;
  end

  assign reading          = (adc.adc_cs_n === 1'b0) && (adc.adc_rd_n === 1'b0);
  assign adc.adc_busy     = (busy_mode == 2) ? 1'b1 :
                            (busy_mode == 1) ? 1'b0 :
                            (conv_age >= busy_delay && conv_age < busy_delay + busy_len);
  assign adc.adc_db       = reading ? ch_data[rd_idx[2:0]] : 16'hdead;
  assign adc.adc_frstdata = reading &&
                            ((rd_idx == frst_bad) ? (rd_idx != 0) : (rd_idx == 0));

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q [$];   // {channel, data}
  int n_cmp = 0;
  int n_err = 0;
  int sv_cnt = 0, fd_cnt = 0, conv_cnt = 0, cyc = 0;
  int t_cv_rise = 0, t_rdy_rise = 0;
  logic cv_prev = 1'b1, rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [18:0] e;
    cyc++;
    if (sample_valid === 1'b1) begin
      sv_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sample: got ch %0d data %0h expected none", sample_ch, sample_data);
      end else begin
        e = exp_q.pop_front();
        check("sample", {13'd0, sample_ch, sample_data}, {13'd0, e});
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (cv_prev === 1'b1 && adc.adc_convst === 1'b0) conv_cnt++;
    if (cv_prev === 1'b0 && adc.adc_convst === 1'b1) t_cv_rise = cyc;
    if (rdy_prev === 1'b0 && ready === 1'b1) t_rdy_rise = cyc;
    cv_prev  = adc.adc_convst;
    rdy_prev = ready;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    while (ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, ready}, 32'd1);
  endtask

  // Counts adc_reset-high cycles until ready rises.
  task automatic measure_reset(input string name);
    int hi = 0;
    int k  = 0;
    while (ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      if (adc.adc_reset === 1'b1) hi++;
      k++;
    end
    check({name, "_width"}, hi, RST_W);
    check({name, "_ready"}, {31'd0, ready}, 32'd1);
    check({name, "_reset_low"}, {31'd0, adc.adc_reset}, 32'd0);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int busy_mode;
    int frst_bad;
    bit start_mid;
    bit rand_data;
    bit exp_timeout;
    bit exp_frst;
    int exp_samples;
    int exp_frames;
    int exp_lat;      // convst-rise to ready-rise cycles, -1 = unchecked
  } vec_t;

  vec_t vecs [7];

  // Reference expectations from the ADC behaviour alone.
  function automatic vec_t ref_vec(input int bm, input int fb, input bit sm);
    vec_t v;
    v.busy_mode   = bm;
    v.frst_bad    = fb;
    v.start_mid   = sm;
    v.rand_data   = 1'b1;
    v.exp_timeout = (bm != 0);
    v.exp_frst    = (bm == 0) && (fb >= 0) && (fb < NCH);
    v.exp_samples = (bm == 0) ? NCH : 0;
    v.exp_frames  = (bm == 0) ? 1 : 0;
    v.exp_lat     = (bm == 1) ? BUSY_TO : -1;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int sv0, fd0, cv0, k;
    wait_ready({tag, "_idle"}, 600);
    busy_mode = v.busy_mode;
    frst_bad  = v.frst_bad;
    for (int c = 0; c < NCH; c++) begin
      ch_data[c] = v.rand_data ? 16'($urandom) : 16'h1000 + 16'(c);
      if (v.busy_mode == 0) exp_q.push_back({3'(c), ch_data[c]});
    end
    tick(5);
    sv0 = sv_cnt;
    fd0 = fd_cnt;
    cv0 = conv_cnt;
    pulse_start();
    check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
    if (v.start_mid) begin
      k = 0;
      while (adc.adc_busy !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      tick(10);
      pulse_start();
    end
    wait_ready({tag, "_ready_back"}, 1500);
    tick(20);
    check({tag, "_convs"}, conv_cnt - cv0, 1);
    check({tag, "_samples"}, sv_cnt - sv0, v.exp_samples);
    check({tag, "_frames"}, fd_cnt - fd0, v.exp_frames);
    check({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, v.exp_timeout});
    check({tag, "_err_frst"}, {31'd0, err_frst}, {31'd0, v.exp_frst});
    check({tag, "_leftover"}, exp_q.size(), 0);
    if (v.exp_lat >= 0) check({tag, "_timeout_lat"}, t_rdy_rise - t_cv_rise, v.exp_lat);
    exp_q.delete();
    busy_mode = 0;
    frst_bad  = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int k;
    rst   = 1'b1;
    power = 1'b0;
    start = 1'b0;
    for (int c = 0; c < NCH; c++) ch_data[c] = 16'h1000 + 16'(c);

    //                busy frst mid rnd  to  frst smp frm  lat
    vecs[0] = '{0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1, -1};
    vecs[1] = '{1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, BUSY_TO};
    vecs[2] = '{0,  3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1, -1};
    vecs[3] = '{0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1, -1};
    vecs[4] = '{2, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, BUSY_TO + 1};
    vecs[5] = '{0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1, -1};
    vecs[6] = '{0,  7, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1, -1};

    // Reset values
    @(negedge clk);
    check("rst_state", dbg_state, OFF);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_adc_reset", {31'd0, adc.adc_reset}, 32'd0);
    check("rst_convst", {31'd0, adc.adc_convst}, 32'd1);
    check("rst_cs_n", {31'd0, adc.adc_cs_n}, 32'd1);
    check("rst_rd_n", {31'd0, adc.adc_rd_n}, 32'd1);
    check("rst_sample", {12'd0, sample_ch, sample_valid, sample_data}, 32'd0);
    check("rst_flags", {29'd0, frame_done, err_timeout, err_frst}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Power-up at 100 ns
    #60;
    power = 1'b1;
    measure_reset("powerup");
    check("idle_convst", {31'd0, adc.adc_convst}, 32'd1);
    check("idle_cs_n", {31'd0, adc.adc_cs_n}, 32'd1);

    // Table-driven frames
    busy_delay = 2;
    busy_len   = 200;
    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Power drop while channel 4 is being read
    wait_ready("pd_idle", 600);
    for (int c = 0; c < NCH; c++) begin
      ch_data[c] = 16'h1000 + 16'(c);
      exp_q.push_back({3'(c), ch_data[c]});
    end
    begin
      int sv0, fd0;
      sv0 = sv_cnt;
      fd0 = fd_cnt;
      pulse_start();
      k = 0;
      while (!(reading && rd_idx == 4) && k < 1000) begin
        @(negedge clk);
        k++;
      end
      check("pd_reach_ch4", {31'd0, k < 1000}, 32'd1);
      power = 1'b0;
      @(negedge clk);
      check("pd_cs_n", {31'd0, adc.adc_cs_n}, 32'd1);
      check("pd_rd_n", {31'd0, adc.adc_rd_n}, 32'd1);
      check("pd_convst", {31'd0, adc.adc_convst}, 32'd1);
      check("pd_state", dbg_state, OFF);
      check("pd_ready", {31'd0, ready}, 32'd0);
      tick(20);
      check("pd_samples", sv_cnt - sv0, 4);
      check("pd_no_frame", fd_cnt - fd0, 0);
      exp_q.delete();
      power = 1'b1;
      measure_reset("pd_restore");
    end

    // Randomized frames against the reference expectations
    for (int i = 0; i < 10; i++) begin
      int bm, fb;
      bm = ($urandom_range(0, 5) == 0) ? 1 : 0;
      fb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      busy_delay = $urandom_range(1, 4);
      busy_len   = $urandom_range(5, 200);
      run_vec($sformatf("r%0d", i), ref_vec(bm, fb, 1'($urandom_range(0, 1))));
    end

    // Reset release with power already high runs the full reset sequence
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    check("rst2_state", dbg_state, OFF);
    check("rst2_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    measure_reset("rst_power_high");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
